// File: rtl/io_mux_nf.sv
// N-function pad multiplexer: registered per-pin function select, pad dead-time on every
// function switch, optional two-flop synchroniser on the pad input path.
module io_mux_nf #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NFUNC       = 4,
    parameter int unsigned SELW        = 2,
    parameter int unsigned DEAD_CYCLES = 2,
    parameter int unsigned SYNC_IN     = 1
) (
    input  logic                   mclk,
    input  logic                   reset_n,
    input  logic                   sel_wr,
    input  logic [WIDTH*SELW-1:0]  sel_wdata,
    output logic [WIDTH*SELW-1:0]  sel_rdata,
    output logic                   busy,
    input  logic [NFUNC*WIDTH-1:0] f_dout,
    input  logic [NFUNC*WIDTH-1:0] f_dout_en,
    output logic [NFUNC*WIDTH-1:0] f_din,
    input  logic [WIDTH-1:0]       io_din,
    output logic [WIDTH-1:0]       io_dout,
    output logic [WIDTH-1:0]       io_dout_en
);

    localparam logic [3:0] CntInit = (DEAD_CYCLES > 0) ? 4'(DEAD_CYCLES - 1) : 4'd0;

    logic [SELW-1:0]  r_tgt_sel [WIDTH];
    logic [SELW-1:0]  r_act_sel [WIDTH];
    logic [3:0]       r_cnt     [WIDTH];
    logic [WIDTH-1:0] r_dead;

    logic [SELW-1:0]  w_new_sel [WIDTH];
    logic [WIDTH-1:0] w_change;
    logic [WIDTH-1:0] w_din_s;

    always_comb begin
        sel_rdata = '0;
        w_change  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_new_sel[i]                = sel_wdata[i*SELW +: SELW];
            w_change[i]                 = sel_wr && (w_new_sel[i] != r_tgt_sel[i]);
            sel_rdata[i*SELW +: SELW]   = r_tgt_sel[i];
        end
    end

    // A changed write always wins over the running count, so a rewrite restarts the dead time.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_dead <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_tgt_sel[i] <= '0;
                r_act_sel[i] <= '0;
                r_cnt[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_change[i]) begin
                    r_tgt_sel[i] <= w_new_sel[i];
                    if (DEAD_CYCLES == 0) begin
                        r_act_sel[i] <= w_new_sel[i];
                    end else begin
                        r_dead[i] <= 1'b1;
                        r_cnt[i]  <= CntInit;
                    end
                end else if (r_dead[i]) begin
                    if (r_cnt[i] != 4'd0) begin
                        r_cnt[i] <= r_cnt[i] - 4'd1;
                    end else begin
                        r_dead[i]    <= 1'b0;
                        r_act_sel[i] <= r_tgt_sel[i];
                    end
                end
            end
        end
    end

    generate
        if (SYNC_IN != 0) begin : g_sync
            logic [WIDTH-1:0] r_sync1;
            logic [WIDTH-1:0] r_sync2;

            always_ff @(posedge mclk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync1 <= '0;
                    r_sync2 <= '0;
                end else begin
                    r_sync1 <= io_din;
                    r_sync2 <= r_sync1;
                end
            end

            assign w_din_s = r_sync2;
        end else begin : g_nosync
            assign w_din_s = io_din;
        end
    endgenerate

    // Selects at or above NFUNC match no function, which parks the pin.
    always_comb begin
        io_dout    = '0;
        io_dout_en = '0;
        f_din      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = 0; k < NFUNC; k++) begin
                if (!r_dead[i] && (r_act_sel[i] == SELW'(k))) begin
                    io_dout[i]         = f_dout[k*WIDTH + i];
                    io_dout_en[i]      = f_dout_en[k*WIDTH + i];
                    f_din[k*WIDTH + i] = w_din_s[i];
                end
            end
        end
    end

    assign busy = |r_dead;

endmodule

// File: tb/tb_io_mux_nf.sv
// Bench for io_mux_nf: three configurations (D=2/NFUNC=4, D=2/NFUNC=3, D=0/no sync) checked
// every cycle against a switch-time model, plus literal directed expectations.
module tb_io_mux_nf;

    localparam int W  = 8;
    localparam int NI = 3;

    logic        mclk      = 1'b0;
    logic        reset_n   = 1'b0;
    logic        sel_wr    = 1'b0;
    logic [15:0] sel_wdata = '0;
    logic [31:0] f_dout    = '0;
    logic [31:0] f_dout_en = '0;
    logic [7:0]  io_din    = '0;
    logic [15:0] sel_img   = '0;
    logic        cmp_en    = 1'b0;

    always #5 mclk = ~mclk;

    logic [15:0] rd0, rd1, rd2;
    logic        b0, b1, b2;
    logic [31:0] fdin0, fdin2;
    logic [23:0] fdin1;
    logic [7:0]  do0, do1, do2, de0, de1, de2;

    io_mux_nf #(.WIDTH(8), .NFUNC(4), .SELW(2), .DEAD_CYCLES(2), .SYNC_IN(1)) u_dut (
        .mclk(mclk), .reset_n(reset_n), .sel_wr(sel_wr), .sel_wdata(sel_wdata),
        .sel_rdata(rd0), .busy(b0), .f_dout(f_dout), .f_dout_en(f_dout_en), .f_din(fdin0),
        .io_din(io_din), .io_dout(do0), .io_dout_en(de0)
    );

    io_mux_nf #(.WIDTH(8), .NFUNC(3), .SELW(2), .DEAD_CYCLES(2), .SYNC_IN(1)) u_park (
        .mclk(mclk), .reset_n(reset_n), .sel_wr(sel_wr), .sel_wdata(sel_wdata),
        .sel_rdata(rd1), .busy(b1), .f_dout(f_dout[23:0]), .f_dout_en(f_dout_en[23:0]),
        .f_din(fdin1), .io_din(io_din), .io_dout(do1), .io_dout_en(de1)
    );

    io_mux_nf #(.WIDTH(8), .NFUNC(4), .SELW(2), .DEAD_CYCLES(0), .SYNC_IN(0)) u_d0 (
        .mclk(mclk), .reset_n(reset_n), .sel_wr(sel_wr), .sel_wdata(sel_wdata),
        .sel_rdata(rd2), .busy(b2), .f_dout(f_dout), .f_dout_en(f_dout_en), .f_din(fdin2),
        .io_din(io_din), .io_dout(do2), .io_dout_en(de2)
    );

    logic [7:0]  a_dout [NI];
    logic [7:0]  a_den  [NI];
    logic [31:0] a_fdin [NI];
    logic [15:0] a_rd   [NI];
    logic        a_busy [NI];

    assign a_dout[0] = do0;
    assign a_dout[1] = do1;
    assign a_dout[2] = do2;
    assign a_den[0]  = de0;
    assign a_den[1]  = de1;
    assign a_den[2]  = de2;
    assign a_fdin[0] = fdin0;
    assign a_fdin[1] = {8'h00, fdin1};
    assign a_fdin[2] = fdin2;
    assign a_rd[0]   = rd0;
    assign a_rd[1]   = rd1;
    assign a_rd[2]   = rd2;
    assign a_busy[0] = b0;
    assign a_busy[1] = b1;
    assign a_busy[2] = b2;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic int cfg_nf(input int j);
        return (j == 1) ? 3 : 4;
    endfunction

    function automatic int cfg_dead(input int j);
        return (j == 2) ? 0 : 2;
    endfunction

    function automatic bit cfg_sync(input int j);
        return (j != 2);
    endfunction

    // Model: a changed select makes the pin dead until edge (write edge + D), then it takes over.
    int         m_tgt   [NI][W];
    int         m_act   [NI][W];
    bit         m_dead  [NI][W];
    int         m_ready [NI][W];
    int         ecount = 0;
    logic [7:0] hist [0:8191];

    always @(posedge mclk or negedge reset_n) begin
        int nv;
        if (!reset_n) begin
            ecount = 0;
            for (int j = 0; j < NI; j++) begin
                for (int i = 0; i < W; i++) begin
                    m_tgt[j][i]   = 0;
                    m_act[j][i]   = 0;
                    m_dead[j][i]  = 1'b0;
                    m_ready[j][i] = 0;
                end
            end
        end else begin
            ecount++;
            hist[ecount] = io_din;
            for (int j = 0; j < NI; j++) begin
                for (int i = 0; i < W; i++) begin
                    nv = int'(sel_wdata[i*2 +: 2]);
                    if (sel_wr && nv != m_tgt[j][i]) begin
                        m_tgt[j][i] = nv;
                        if (cfg_dead(j) == 0) begin
                            m_act[j][i] = nv;
                        end else begin
                            m_dead[j][i]  = 1'b1;
                            m_ready[j][i] = ecount + cfg_dead(j);
                        end
                    end else if (m_dead[j][i] && ecount >= m_ready[j][i]) begin
                        m_dead[j][i] = 1'b0;
                        m_act[j][i]  = m_tgt[j][i];
                    end
                end
            end
        end
    end

    function automatic logic [7:0] din_s(input int j);
        if (!cfg_sync(j)) return io_din;
        return (ecount >= 2) ? hist[ecount-1] : 8'h00;
    endfunction

    always @(negedge mclk) begin
        logic [7:0]  e_dout, e_den, ds;
        logic [31:0] e_fdin;
        logic [15:0] e_rd;
        logic        e_busy;
        int          k;
        if (cmp_en) begin
            for (int j = 0; j < NI; j++) begin
                e_dout = '0;
                e_den  = '0;
                e_fdin = '0;
                e_rd   = '0;
                e_busy = 1'b0;
                ds     = din_s(j);
                for (int i = 0; i < W; i++) begin
                    e_rd[i*2 +: 2] = 2'(m_tgt[j][i]);
                    if (m_dead[j][i]) begin
                        e_busy = 1'b1;
                    end else if (m_act[j][i] < cfg_nf(j)) begin
                        k              = m_act[j][i];
                        e_dout[i]      = f_dout[k*W + i];
                        e_den[i]       = f_dout_en[k*W + i];
                        e_fdin[k*W + i] = ds[i];
                    end
                end
                check($sformatf("u%0d io_dout", j), {24'h0, a_dout[j]}, {24'h0, e_dout});
                check($sformatf("u%0d io_dout_en", j), {24'h0, a_den[j]}, {24'h0, e_den});
                check($sformatf("u%0d f_din", j), a_fdin[j], e_fdin);
                check($sformatf("u%0d sel_rdata", j), {16'h0, a_rd[j]}, {16'h0, e_rd});
                check($sformatf("u%0d busy", j), {31'h0, a_busy[j]}, {31'h0, e_busy});
            end
        end
    end

    // Call just after a posedge; the write is sampled on the next edge.
    task automatic drive_wr(input logic [15:0] v);
        sel_wr    = 1'b1;
        sel_wdata = v;
        @(posedge mclk);
        #1;
        sel_wr = 1'b0;
    endtask

    initial begin
        f_dout    = {8'h0E, 8'h08, 8'h20, 8'hA5};
        f_dout_en = {8'hFF, 8'h08, 8'hFF, 8'hFF};
        repeat (2) @(posedge mclk);
        #1;
        check("rst io_dout", {24'h0, do0}, 32'hA5);
        check("rst io_dout_en", {24'h0, de0}, 32'hFF);
        check("rst sel_rdata", {16'h0, rd0}, 32'h0);
        check("rst busy", {31'h0, b0}, 32'h0);
        cmp_en  = 1'b1;
        reset_n = 1'b1;
        repeat (3) @(posedge mclk);
        #1;

        // Pin 3: function 0 -> 2, dead for exactly two cycles.
        sel_img[7:6] = 2'd2;
        drive_wr(sel_img);
        @(negedge mclk);
        check("p3 dead1 en", {24'h0, de0}, 32'hF7);
        check("p3 dead1 dout", {24'h0, do0}, 32'hA5);
        check("p3 dead1 busy", {31'h0, b0}, 32'h1);
        @(negedge mclk);
        check("p3 dead2 en", {24'h0, de0}, 32'hF7);
        check("p3 dead2 busy", {31'h0, b0}, 32'h1);
        @(negedge mclk);
        check("p3 live en", {24'h0, de0}, 32'hFF);
        check("p3 live dout", {24'h0, do0}, 32'hAD);
        check("p3 live busy", {31'h0, b0}, 32'h0);

        // Pin 0: 0 -> 1, then 3 one cycle later; dead 1+D cycles in total.
        @(posedge mclk);
        #1;
        sel_img[1:0] = 2'd1;
        drive_wr(sel_img);
        sel_img[1:0] = 2'd3;
        drive_wr(sel_img);
        @(negedge mclk);
        check("p0 rewrite dead a", {24'h0, de0}, 32'hFE);
        @(negedge mclk);
        check("p0 rewrite dead b", {24'h0, de0}, 32'hFE);
        check("p0 rewrite busy", {31'h0, b0}, 32'h1);
        @(negedge mclk);
        check("p0 f3 en", {24'h0, de0}, 32'hFF);
        check("p0 f3 dout", {24'h0, do0}, 32'hAC);

        // Pin 5 on function 1: two-cycle input latency.
        @(posedge mclk);
        #1;
        sel_img[11:10] = 2'd1;
        drive_wr(sel_img);
        repeat (3) @(posedge mclk);
        #1;
        io_din[5] = 1'b1;
        @(negedge mclk);
        check("din rise +0", {31'h0, fdin0[13]}, 32'h0);
        @(negedge mclk);
        check("din rise +1", {31'h0, fdin0[13]}, 32'h0);
        @(negedge mclk);
        check("din rise +2", {31'h0, fdin0[13]}, 32'h1);
        check("din f0 pin5", {31'h0, fdin0[5]}, 32'h0);
        @(posedge mclk);
        #1;
        io_din[5] = 1'b0;
        @(negedge mclk);
        check("din fall +0", {31'h0, fdin0[13]}, 32'h1);
        @(negedge mclk);
        @(negedge mclk);
        check("din fall +2", {31'h0, fdin0[13]}, 32'h0);

        // Pin 6 to select 3: parked on the NFUNC=3 instance, function 3 on the other.
        @(posedge mclk);
        #1;
        sel_img[13:12] = 2'd3;
        drive_wr(sel_img);
        io_din = 8'hFF;
        repeat (4) @(negedge mclk);
        for (int c = 0; c < 3; c++) begin
            check("park en", {31'h0, de1[6]}, 32'h0);
            check("park dout", {31'h0, do1[6]}, 32'h0);
            check("park f_din", {29'h0, fdin1[22], fdin1[14], fdin1[6]}, 32'h0);
            check("park pin5 f1", {31'h0, fdin1[13]}, 32'h1);
            check("f3 pin6 en", {31'h0, de0[6]}, 32'h1);
            @(negedge mclk);
        end

        // Reset in the middle of a dead period.
        @(posedge mclk);
        #1;
        sel_img[15:14] = 2'd2;
        drive_wr(sel_img);
        #1;
        check("pre-rst busy", {31'h0, b0}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid rst dout", {24'h0, do0}, 32'hA5);
        check("mid rst en", {24'h0, de0}, 32'hFF);
        check("mid rst busy", {31'h0, b0}, 32'h0);
        check("mid rst sel_rdata", {16'h0, rd0}, 32'h0);
        check("mid rst f_din", fdin0, 32'h0);
        @(posedge mclk);
        #1;
        reset_n = 1'b1;
        sel_img = '0;

        for (int c = 0; c < 600; c++) begin
            @(posedge mclk);
            #1;
            f_dout    = $urandom();
            f_dout_en = $urandom();
            io_din    = 8'($urandom());
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < W; i++) begin
                    if ($urandom_range(0, 2) == 0) sel_img[i*2 +: 2] = 2'($urandom_range(0, 3));
                end
                sel_wr    = 1'b1;
                sel_wdata = sel_img;
            end else begin
                sel_wr    = 1'b0;
                sel_wdata = 16'($urandom());
            end
            if (c == 300) begin
                #2;
                reset_n = 1'b0;
                #3;
                reset_n = 1'b1;
                sel_img = '0;
            end
        end
        @(posedge mclk);
        #1;
        sel_wr = 1'b0;
        repeat (5) @(negedge mclk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
